// File: rtl/baud_gen_frac.sv
// baud_gen_frac -- fractional-N baud tick generator.
//
// A phase accumulator adds the active increment every enabled cycle; each
// carry out of the accumulator is one oversample tick. A modulo-OVS counter
// of those ticks marks bit boundaries (and, optionally, mid-bit samples).
// A new increment is staged in a pending register and only applied at a bit
// boundary, while disabled, or on restart, so a running bit never changes rate.
//
// Optional feature macro: BAUDGEN_MIDBIT_EN (enables the tick_mid comparator;
// without it tick_mid is tied to 0).
//
// Ports:
//   clk       in   clock, all state on rising edge
//   reset     in   synchronous active-high reset
//   enable    in   accumulator advances when high
//   restart   in   phase realign pulse (acc to half scale, ovs count to 0)
//   inc_in    in   [ACC_W] new increment value
//   inc_load  in   one-cycle strobe capturing inc_in
//   inc_busy  out  captured increment pending, not yet applied
//   tick_ovs  out  one-cycle oversample tick
//   tick_bit  out  one-cycle bit-boundary tick
//   tick_mid  out  one-cycle mid-bit tick
module baud_gen_frac #(
    parameter int          ACC_W     = 16,
    parameter int          OVS       = 16,
    parameter int unsigned INC_RESET = 2416
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             restart,
    input  logic [ACC_W-1:0] inc_in,
    input  logic             inc_load,
    output logic             inc_busy,
    output logic             tick_ovs,
    output logic             tick_bit,
    output logic             tick_mid
);

    localparam int               CNT_W       = $clog2(OVS);
    localparam logic [ACC_W-1:0] LP_INC_RST  = INC_RESET[ACC_W-1:0];
    localparam logic [ACC_W-1:0] LP_ACC_HALF = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(OVS - 1);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc_act;
    logic [ACC_W-1:0] r_inc_pend;
    logic [CNT_W-1:0] r_ovs_cnt;
    logic             r_inc_busy;
    logic             r_tick_ovs;
    logic             r_tick_bit;

    logic [ACC_W:0]   w_sum;
    logic             w_tick_ev;
    logic             w_cnt_last;
    logic             w_apply;

    assign w_sum      = {1'b0, r_acc} + {1'b0, r_inc_act};
    // A carry only counts as a tick when the accumulator actually advances;
    // the carry of a restart cycle is thrown away with the old phase.
    assign w_tick_ev  = enable & ~restart & w_sum[ACC_W];
    assign w_cnt_last = (r_ovs_cnt == LP_CNT_LAST);
    // Pending increment is applied only where no bit is in flight at the old
    // rate: the boundary carry itself, any disabled cycle, or a restart.
    assign w_apply    = r_inc_busy & (restart | ~enable | (w_tick_ev & w_cnt_last));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_ovs_cnt  <= '0;
            r_inc_act  <= LP_INC_RST;
            r_inc_pend <= '0;
            r_inc_busy <= 1'b0;
            r_tick_ovs <= 1'b0;
            r_tick_bit <= 1'b0;
        end else begin
            r_tick_ovs <= w_tick_ev;
            r_tick_bit <= w_tick_ev & w_cnt_last;

            if (restart) begin
                r_acc     <= LP_ACC_HALF;
                r_ovs_cnt <= '0;
            end else if (enable) begin
                r_acc <= w_sum[ACC_W-1:0];
                if (w_sum[ACC_W])
                    r_ovs_cnt <= w_cnt_last ? '0 : r_ovs_cnt + CNT_W'(1);
            end

            if (w_apply)
                r_inc_act <= r_inc_pend;

            // A load in an apply cycle: the old pending value is applied above
            // and the new one stays pending.
            if (inc_load) begin
                r_inc_pend <= inc_in;
                r_inc_busy <= 1'b1;
            end else if (w_apply) begin
                r_inc_busy <= 1'b0;
            end
        end
    end

`ifdef BAUDGEN_MIDBIT_EN
    localparam logic [CNT_W-1:0] LP_CNT_MID = CNT_W'(OVS/2 - 1);
    logic r_tick_mid;

    always_ff @(posedge clk) begin
        if (reset)
            r_tick_mid <= 1'b0;
        else
            r_tick_mid <= w_tick_ev & (r_ovs_cnt == LP_CNT_MID);
    end

    assign tick_mid = r_tick_mid;
`else
    assign tick_mid = 1'b0;
`endif

    assign inc_busy = r_inc_busy;
    assign tick_ovs = r_tick_ovs;
    assign tick_bit = r_tick_bit;

endmodule
